// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Requests use valid/ready; responses come back in order with no backpressure.
interface if_stage_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited imem requests, in-order response buffer, redirect squash.
// Optional macro IF_PERF_CNT_EN adds fetch and squash performance counters.
module if_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  arst_n,
    if_stage_if.master            imem,
    input  logic                  redirect_in,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
    output logic                  if_valid_out,
    input  logic                  id_ready_in,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] pc_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt_out,
    output logic [31:0]           perf_squash_cnt_out
`endif
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]      fifo_rd_q, fifo_rd_d;
    logic [PTR_W-1:0]      fifo_wr_q, fifo_wr_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [PTR_W-1:0]      pcq_rd_q, pcq_rd_d;
    logic [PTR_W-1:0]      pcq_wr_q, pcq_wr_d;
    logic                  started_q;
    logic [ADDR_WIDTH-1:0] pc_last_q;

    logic [DATA_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pcq_q       [FIFO_DEPTH];

    logic fifo_nonempty, req_fire, rsp_drop, push, pop;
    logic unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_in[1:0];
    assign fifo_nonempty  = (fifo_cnt_q != '0);

    // In-flight requests plus buffered entries never exceed the buffer depth.
    assign imem.imem_req_valid = started_q & ~redirect_in &
                                 (({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < SUM_W'(FIFO_DEPTH));
    assign imem.imem_req_addr  = pc_q;

    assign if_valid_out = fifo_nonempty;
    assign inst_out     = fifo_nonempty ? fifo_inst_q[fifo_rd_q] : NOP;
    assign pc_out       = fifo_nonempty ? fifo_pc_q[fifo_rd_q]   : pc_last_q;

    always_comb begin
        req_fire   = imem.imem_req_valid & imem.imem_req_ready;
        rsp_drop   = imem.imem_rsp_valid & (redirect_in | (discard_q != '0));
        push       = imem.imem_rsp_valid & ~rsp_drop;
        pop        = fifo_nonempty & id_ready_in & ~redirect_in;
        pc_d       = pc_q;
        fifo_cnt_d = fifo_cnt_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(imem.imem_rsp_valid);
        pcq_wr_d   = pcq_wr_q + PTR_W'(req_fire);
        pcq_rd_d   = pcq_rd_q + PTR_W'(imem.imem_rsp_valid);
        if (redirect_in) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d       = {redirect_pc_in[ADDR_WIDTH-1:2], 2'b00};
            fifo_cnt_d = '0;
            fifo_rd_d  = fifo_wr_q;
            discard_d  = outst_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + ADDR_WIDTH'(4);
            end
            fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
            fifo_rd_d  = fifo_rd_q + PTR_W'(pop);
            fifo_wr_d  = fifo_wr_q + PTR_W'(push);
            discard_d  = discard_q - CNT_W'(rsp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            pc_q       <= RESET_PC;
            fifo_cnt_q <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
            started_q  <= 1'b0;
            pc_last_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
            started_q  <= 1'b1;
            pc_last_q  <= pc_out;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_q[pcq_wr_q] <= pc_q;
        end
        if (push) begin
            fifo_inst_q[fifo_wr_q] <= imem.imem_rsp_data;
            fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_squash_q;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            perf_fetch_q  <= '0;
            perf_squash_q <= '0;
        end else begin
            perf_fetch_q  <= perf_fetch_q + 32'(pop);
            perf_squash_q <= perf_squash_q + 32'(rsp_drop) +
                             (redirect_in ? 32'(fifo_cnt_q) : 32'd0);
        end
    end

    assign perf_fetch_cnt_out  = perf_fetch_q;
    assign perf_squash_cnt_out = perf_squash_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: random imem/decode/redirect traffic checked every cycle against a
// queue-based fetch model with epoch-tagged requests, plus directed literal scenarios.
module tb_if_stage;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        if_valid_out;
    logic        id_ready_in;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_squash;
`endif

    if_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    if_stage #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .imem          (bus),
        .redirect_in   (redirect_in),
        .redirect_pc_in(redirect_pc_in),
        .if_valid_out  (if_valid_out),
        .id_ready_in   (id_ready_in),
        .inst_out      (inst_out),
        .pc_out        (pc_out)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt_out (perf_fetch),
        .perf_squash_cnt_out(perf_squash)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     pc;
        int unsigned     epoch;
        longint unsigned due;
    } req_t;

    req_t            memq[$];
    req_t            rsp_item;
    logic            rsp_v;
    logic [31:0]     outq[$];
    logic [31:0]     exp_pc, last_pc, disp_pc;
    int unsigned     epoch;
    logic            started, model_ok, exp_rv;
    logic [31:0]     fetch_m, squash_m;
    longint unsigned cyc;
    int              n_tests, n_fail;

    int unsigned ready_pct, idr_pct, redir_pct, lat_min, lat_max;
    logic        rst_k, redir_force;
    logic [31:0] redir_tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom();
        if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
        return t;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    function automatic void model_reset();
        memq.delete();
        outq.delete();
        exp_pc   = 32'h0;
        last_pc  = 32'h0;
        epoch    = 0;
        fetch_m  = 32'h0;
        squash_m = 32'h0;
        started  = 1'b0;
        model_ok = 1'b1;
    endfunction

    // Single place where DUT outputs are compared with the model each cycle.
    function automatic void compare();
        int inflight;
        inflight = memq.size() + (rsp_v ? 1 : 0);
        exp_rv   = started && !redirect_in && ((inflight + outq.size()) < int'(DEPTH));
        disp_pc  = (outq.size() != 0) ? outq[0] : last_pc;
        chk("if_valid", if_valid_out, outq.size() != 0);
        chk("inst", inst_out, (outq.size() != 0) ? mem_word(outq[0]) : NOP);
        chk("pc_out", pc_out, disp_pc);
        chk("req_valid", bus.imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", bus.imem_req_addr, exp_pc);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", perf_fetch, fetch_m);
        chk("perf_squash", perf_squash, squash_m);
`endif
    endfunction

    task automatic drive();
        @(negedge clk);
        arst_n             = rst_k;
        bus.imem_req_ready = ($urandom_range(99) < ready_pct);
        id_ready_in        = ($urandom_range(99) < idr_pct);
        if (redir_force) begin
            redirect_in    = 1'b1;
            redirect_pc_in = redir_tgt;
            redir_force    = 1'b0;
        end else begin
            redirect_in    = ($urandom_range(99) < redir_pct);
            redirect_pc_in = rand_target();
        end
        rsp_v = 1'b0;
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            rsp_item = memq.pop_front();
            rsp_v    = 1'b1;
        end
        bus.imem_rsp_valid = rsp_v;
        bus.imem_rsp_data  = rsp_v ? mem_word(rsp_item.pc) : $urandom();
        #1;
        if (model_ok) compare();
    endtask

    task automatic advance();
        logic fire, pop;
        if (model_ok && arst_n) begin
            fire    = exp_rv && bus.imem_req_ready;
            pop     = (outq.size() != 0) && id_ready_in && !redirect_in;
            last_pc = disp_pc;
            if (pop) begin
                void'(outq.pop_front());
                fetch_m++;
            end
            if (rsp_v) begin
                if (!redirect_in && rsp_item.epoch == epoch) outq.push_back(rsp_item.pc);
                else squash_m++;
            end
            if (redirect_in) begin
                squash_m = squash_m + 32'(outq.size());
                outq.delete();
                epoch++;
                exp_pc = {redirect_pc_in[31:2], 2'b00};
            end
            if (fire) begin
                memq.push_back('{pc: exp_pc, epoch: epoch,
                                 due: cyc + longint'($urandom_range(lat_max, lat_min))});
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        if (!arst_n) model_reset();
        else started = 1'b1;
    endtask

    task automatic cycle();
        drive();
        advance();
    endtask

    task automatic set_knobs(input int unsigned r, input int unsigned d, input int unsigned rd,
                             input int unsigned lmin, input int unsigned lmax);
        ready_pct = r;
        idr_pct   = d;
        redir_pct = rd;
        lat_min   = lmin;
        lat_max   = lmax;
    endtask

    task automatic do_reset();
        rst_k = 1'b0;
        cycle();
        drive();
        chk("rst_if_valid", if_valid_out, 1'b0);
        chk("rst_inst", inst_out, 32'h0000_0013);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_req_valid", bus.imem_req_valid, 1'b0);
        advance();
        rst_k = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_b[3];
        int          got;
        exp_b       = '{32'h0, 32'h4, 32'h8};
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        model_ok    = 1'b0;
        started     = 1'b0;
        redir_force = 1'b0;
        redir_tgt   = 32'h0;
        rst_k       = 1'b0;

        // Streaming with 1-cycle memory and ready decode.
        set_knobs(100, 100, 0, 1, 1);
        do_reset();
        drive(); chk("A_req_valid_release", bus.imem_req_valid, 1'b0); advance();
        drive(); chk("A_req0_valid", bus.imem_req_valid, 1'b1);
                 chk("A_req0_addr", bus.imem_req_addr, 32'h0); advance();
        drive(); chk("A_req1_addr", bus.imem_req_addr, 32'h4);
                 chk("A_valid_early", if_valid_out, 1'b0); advance();
        drive(); chk("A_first_valid", if_valid_out, 1'b1);
                 chk("A_first_pc", pc_out, 32'h0); advance();
        drive(); chk("A_second_pc", pc_out, 32'h4); advance();
        repeat (10) cycle();

        // Decode stalls until the buffer fills, then drains in order.
        set_knobs(100, 0, 0, 1, 1);
        do_reset();
        repeat (4) cycle();
        repeat (3) begin
            drive();
            chk("B_full_req_valid", bus.imem_req_valid, 1'b0);
            chk("B_full_valid", if_valid_out, 1'b1);
            chk("B_full_pc", pc_out, 32'h0);
            advance();
        end
        idr_pct = 100;
        got = 0;
        for (int k = 0; k < 12 && got < 3; k++) begin
            drive();
            if (if_valid_out) begin
                chk($sformatf("B_pop%0d", got), pc_out, exp_b[got]);
                got++;
            end
            advance();
        end
        chk("B_pops_seen", got, 3);

        // Redirect with two requests outstanding at latency 3.
        set_knobs(100, 100, 0, 3, 3);
        do_reset();
        repeat (3) cycle();
        redir_force = 1'b1;
        redir_tgt   = 32'h100;
        drive(); chk("C_req_blocked", bus.imem_req_valid, 1'b0); advance();
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            drive();
            if (bus.imem_req_valid) begin
                chk("C_addr_after_redirect", bus.imem_req_addr, 32'h100);
                got = 1;
            end
            advance();
        end
        chk("C_req_seen", got, 1);
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            drive();
            if (if_valid_out) begin
                chk("C_first_valid_pc", pc_out, 32'h100);
                got = 1;
            end
            advance();
        end
        chk("C_valid_seen", got, 1);

        // Unaligned redirect target is word-aligned.
        redir_force = 1'b1;
        redir_tgt   = 32'h203;
        cycle();
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            drive();
            if (bus.imem_req_valid) begin
                chk("D_addr_aligned", bus.imem_req_addr, 32'h200);
                got = 1;
            end
            advance();
        end
        chk("D_req_seen", got, 1);

        // Memory not ready: request held stable.
        set_knobs(0, 100, 0, 1, 1);
        do_reset();
        cycle();
        repeat (5) begin
            drive();
            chk("E_hold_valid", bus.imem_req_valid, 1'b1);
            chk("E_hold_addr", bus.imem_req_addr, 32'h0);
            advance();
        end
        ready_pct = 100;
        drive(); chk("E_resume_addr0", bus.imem_req_addr, 32'h0); advance();
        drive(); chk("E_resume_addr1", bus.imem_req_addr, 32'h4); advance();

        // Redirect coinciding with a response and a pop.
        set_knobs(100, 100, 0, 1, 1);
        do_reset();
        repeat (3) cycle();
        redir_force = 1'b1;
        redir_tgt   = 32'h40;
        drive(); chk("F_valid_before", if_valid_out, 1'b1); advance();
        drive();
        chk("F_valid_after", if_valid_out, 1'b0);
        chk("F_req_addr", bus.imem_req_addr, 32'h40);
`ifdef IF_PERF_CNT_EN
        chk("F_perf_squash", perf_squash, 32'd2);
        chk("F_perf_fetch", perf_fetch, 32'd0);
`endif
        advance();

        // Randomized traffic.
        set_knobs(70, 60, 3, 1, 4);
        repeat (2500) cycle();
        set_knobs(100, 100, 0, 1, 1);
        repeat (1500) cycle();
        do_reset();
        set_knobs(50, 30, 10, 1, 6);
        repeat (2500) cycle();
        set_knobs(90, 90, 30, 1, 3);
        repeat (2500) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage, directly upstream of instruction decode.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel, with in-order responses.
- Buffers returned instructions in a small FIFO and presents {inst, pc} to decode under a valid/ready handshake.
- Accepts redirects from later stages (branch/jump) and squashes all in-flight and buffered fetches.

Parameters:
- DATA_WIDTH, 32, instruction/data word width.
- ADDR_WIDTH, 32, PC and fetch address width.
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock, all state on rising edge.
- arst_n  in  1  reset, synchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_WIDTH  fetch address (word aligned).
- imem_rsp_valid  in  1  response valid; in order, latency ≥1 cycle, no backpressure.
- imem_rsp_data  in  DATA_WIDTH  fetched instruction.
- redirect_in  in  1  redirect request.
- redirect_pc_in  in  ADDR_WIDTH  redirect target.
- if_valid_out  out  1  inst_out/pc_out valid to decode.
- id_ready_in  in  1  decode accepts.
- inst_out  out  DATA_WIDTH  instruction; drives id_stage_in.inst.
- pc_out  out  ADDR_WIDTH  PC of inst_out.

Behaviour:
- Reset (arst_n=0 sampled at clk):
  - pc_q=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - if_valid_out=0; inst_out=32'h0000_0013 (NOP); pc_out=0; imem_req_valid=0 during reset and in the first cycle after release.
- Credit rule: imem_req_valid=1 iff outstanding + fifo_count < FIFO_DEPTH and redirect_in=0. The FIFO therefore never overflows.
- imem_req_addr = pc_q. On handshake: pc_q += 4 (wraps modulo 2^ADDR_WIDTH); outstanding++.
- Each request's PC travels with it in an internal PC queue (FIFO_DEPTH entries) and is pushed together with its response.
- Response with discard=0: push {data, pc} into the FIFO. Response with discard>0: drop it, discard--. Either way outstanding--.
- Output: if_valid_out = (fifo_count≠0); inst_out/pc_out = head entry. When empty, inst_out=NOP and pc_out holds its last value.
- Pop on if_valid_out & id_ready_in. Push and pop in the same cycle are allowed (count unchanged; a full FIFO may push when popping).
- Redirect (redirect_in=1), highest priority:
  - pc_q <= {redirect_pc_in[ADDR_WIDTH-1:2], 2'b00}; FIFO flushed; any pop that cycle is ignored.
  - discard <= outstanding_after_this_cycle: all requests in flight, including one accepted the previous cycle, are squashed.
  - A response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle; fetch resumes at the new pc_q the next cycle.
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- Zero-latency responses are not supported (latency ≥1 is a protocol rule).
- No combinational path from imem_rsp_* to if_valid_out: one-cycle minimum from response to valid.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt_out[31:0], counting instructions popped to decode, and perf_squash_cnt_out[31:0], counting FIFO entries flushed plus responses discarded.
  - Both reset to 0 and wrap at 2^32.
- Not defined: ports and counters are absent; functional behaviour is identical.

Test Plan:
- Reset release, memory always ready with 1-cycle latency, id_ready_in=1 → requests at 0x0, 0x4, 0x8…; first if_valid_out=1 with pc_out=0x0 two cycles after first request; one instruction per cycle thereafter.
- Hold id_ready_in=0 after 2 responses → FIFO full, imem_req_valid=0; release → pops in order 0x0, 0x4, then fetch resumes at 0x8 with no loss or duplication.
- Redirect to 0x100 with 2 requests outstanding (latency 3) → both responses dropped, FIFO flushed, next request addr=0x100, first valid pc_out=0x100.
- Redirect_pc_in=0x203 → next request addr=0x200.
- imem_req_ready=0 for 5 cycles → pc_q stays constant, imem_req_addr stable while imem_req_valid=1.
- Redirect in the same cycle as a response and a pop → response dropped, pop ignored, if_valid_out=0 next cycle; with IF_PERF_CNT_EN, perf_squash_cnt_out increments by flushed+dropped count.
